// File: rtl/peltier_loop_master_if.sv
// peltier_loop_master_if
//   Byte-stream link between the Peltier loop master and the command
//   dispatcher FIFOs.
//   cmd_wdata / cmd_winc / cmd_wfull : write side of the dispatcher rx FIFO
//   rsp_rdata / rsp_rinc / rsp_rempty: read side of the dispatcher tx FIFO
//                                      (first-word-fall-through)
//   master modport: the loop master (drives writes and pops)
//   slave modport : the FIFO side
interface peltier_loop_master_if;
  logic [7:0] cmd_wdata;
  logic       cmd_winc;
  logic       cmd_wfull;
  logic [7:0] rsp_rdata;
  logic       rsp_rinc;
  logic       rsp_rempty;

  modport master (
    output cmd_wdata, cmd_winc, rsp_rinc,
    input  cmd_wfull, rsp_rdata, rsp_rempty
  );

  modport slave (
    input  cmd_wdata, cmd_winc, rsp_rinc,
    output cmd_wfull, rsp_rdata, rsp_rempty
  );
endinterface

// File: rtl/peltier_loop_master.sv
// peltier_loop_master
//   Autonomous command initiator standing in for the FT245 host. On each
//   enabled tick it drains stale response bytes, requests an MCP3008 sample,
//   collects the 4-byte little-endian response, computes a proportional
//   Peltier duty and writes it to both Peltier channels. Enable level changes
//   are turned into Peltier on/off commands.
//
//   Ports
//     clk, rst     : clock, synchronous active-high reset
//     enable       : loop enable (level)
//     tick         : one-cycle sample strobe, honoured only in IDLE
//     setpoint     : target ADC code
//     bus          : master side of peltier_loop_master_if (cmd/rsp FIFOs)
//     temp         : last valid 10-bit reading
//     duty         : last duty byte sent
//     busy         : FSM not in IDLE
//     timeout_err  : the last sample cycle timed out
//
//   Optional feature: define PELTIER_LOOP_FAILSAFE_EN to switch the Peltiers
//   off (and force a fresh CMD_PELTIER_ON later) when a response times out.
module peltier_loop_master #(
  parameter int TEMP_LSB       = 0,
  parameter int KP_SHIFT       = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  tick,
  input  logic [9:0]            setpoint,
  peltier_loop_master_if.master bus,
  output logic [9:0]            temp,
  output logic [7:0]            duty,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam logic [7:0] CMD_GET_MCP       = 8'h01;
  localparam logic [7:0] CMD_PELTIER_ON    = 8'h05;
  localparam logic [7:0] CMD_PELTIER_OFF   = 8'h06;
  localparam logic [7:0] CMD_PELTIER_1_SET = 8'h07;
  localparam logic [7:0] CMD_PELTIER_2_SET = 8'h08;

  // Shifted error is kept at full width so saturation sees every carried bit.
  localparam int          MAG_W   = 11 + KP_SHIFT;
  // The counter starts at 0 on the first COLLECT cycle, so the cycle holding
  // TIMEOUT_CYCLES-1 is the last one allowed to wait.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    SEND_ON,
    SEND_OFF,
    DRAIN,
    SEND_GET,
    COLLECT,
    CALC,
    P1_CMD,
    P1_VAL,
    P2_CMD,
    P2_VAL
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        on_sent;
  logic [31:0] word;
  logic [1:0]  byte_cnt;
  logic [15:0] to_cnt;
  logic        to_hit;
  logic        pop;
  logic        wr;
  logic [7:0]  wdata;
  logic [9:0]  temp_calc;
  logic [7:0]  duty_calc;
  logic        word_unused;

  // Proportional duty: negative or zero error gives 0, otherwise the shifted
  // error clipped to a full byte.
  function automatic logic [7:0] sat_duty(input logic [9:0] t, input logic [9:0] sp);
    logic signed [10:0] err;
    logic [MAG_W-1:0]   mag;
    err = $signed({1'b0, t}) - $signed({1'b0, sp});
    if (err <= 11'sd0) return 8'd0;
    mag = MAG_W'($unsigned(err)) << KP_SHIFT;
    if (mag > MAG_W'(255)) return 8'hFF;
    return mag[7:0];
  endfunction

  assign temp_calc   = word[TEMP_LSB +: 10];
  assign duty_calc   = sat_duty(temp_calc, setpoint);
  // Only part of the response word carries the reading.
  assign word_unused = ^word;

  always_comb begin
    state_n = state;
    wdata   = 8'h00;
    wr      = 1'b0;
    pop     = 1'b0;
    to_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !on_sent)      state_n = SEND_ON;
        else if (!enable && on_sent) state_n = SEND_OFF;
        else if (enable && tick)     state_n = DRAIN;
      end
      SEND_ON: begin
        wdata = CMD_PELTIER_ON;
        wr    = !bus.cmd_wfull;
        if (wr) state_n = IDLE;
      end
      SEND_OFF: begin
        wdata = CMD_PELTIER_OFF;
        wr    = !bus.cmd_wfull;
        if (wr) state_n = IDLE;
      end
      DRAIN: begin
        pop = !bus.rsp_rempty;
        if (bus.rsp_rempty) state_n = SEND_GET;
      end
      SEND_GET: begin
        wdata = CMD_GET_MCP;
        wr    = !bus.cmd_wfull;
        if (wr) state_n = COLLECT;
      end
      COLLECT: begin
        to_hit = (to_cnt == TO_LAST);
        // A byte showing up on the timeout cycle is left in the FIFO; the
        // next DRAIN discards it.
        if (to_hit) begin
`ifdef PELTIER_LOOP_FAILSAFE_EN
          state_n = SEND_OFF;
`else
          state_n = IDLE;
`endif
        end else if (!bus.rsp_rempty) begin
          pop = 1'b1;
          if (byte_cnt == 2'd3) state_n = CALC;
        end
      end
      CALC: state_n = P1_CMD;
      P1_CMD: begin
        wdata = CMD_PELTIER_1_SET;
        wr    = !bus.cmd_wfull;
        if (wr) state_n = P1_VAL;
      end
      P1_VAL: begin
        wdata = duty;
        wr    = !bus.cmd_wfull;
        if (wr) state_n = P2_CMD;
      end
      P2_CMD: begin
        wdata = CMD_PELTIER_2_SET;
        wr    = !bus.cmd_wfull;
        if (wr) state_n = P2_VAL;
      end
      P2_VAL: begin
        wdata = duty;
        wr    = !bus.cmd_wfull;
        if (wr) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.cmd_wdata = wdata;
  assign bus.cmd_winc  = wr;
  assign bus.rsp_rinc  = pop;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      on_sent     <= 1'b0;
      byte_cnt    <= 2'd0;
      to_cnt      <= 16'd0;
      temp        <= 10'd0;
      duty        <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == SEND_ON && wr)  on_sent <= 1'b1;
      if (state == SEND_OFF && wr) on_sent <= 1'b0;
      // Held at zero while waiting to send the request, so COLLECT always
      // starts from a fresh byte count and timeout count.
      if (state == SEND_GET) begin
        byte_cnt <= 2'd0;
        to_cnt   <= 16'd0;
      end
      if (state == COLLECT) begin
        to_cnt <= to_cnt + 16'd1;
        if (pop) byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == CALC) begin
        temp        <= temp_calc;
        duty        <= duty_calc;
        timeout_err <= 1'b0;
      end
      if (to_hit) begin
        timeout_err <= 1'b1;
`ifdef PELTIER_LOOP_FAILSAFE_EN
        on_sent     <= 1'b0;
`endif
      end
    end
  end

  // Response assembly, little-endian; a partial word is simply overwritten
  // by the next complete response.
  always_ff @(posedge clk) begin
    if (state == COLLECT && pop) begin
      case (byte_cnt)
        2'd0:    word[7:0]   <= bus.rsp_rdata;
        2'd1:    word[15:8]  <= bus.rsp_rdata;
        2'd2:    word[23:16] <= bus.rsp_rdata;
        default: word[31:24] <= bus.rsp_rdata;
      endcase
    end
  end

endmodule

// File: tb/tb_peltier_loop_master.sv
// tb_peltier_loop_master
//   Bench for peltier_loop_master (TIMEOUT_CYCLES overridden to 20). Models
//   the dispatcher rx FIFO as a write log and the tx FIFO as a byte queue,
//   runs a table of directed sample cycles, hand-written corner sequences and
//   randomized cycles checked against a duty model computed from the
//   proportional-control rules.
module tb_peltier_loop_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       tick;
  logic [9:0] setpoint;
  logic [9:0] temp;
  logic [7:0] duty;
  logic       busy;
  logic       timeout_err;

  peltier_loop_master_if bus();

  peltier_loop_master #(.TIMEOUT_CYCLES(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .tick        (tick),
    .setpoint    (setpoint),
    .bus         (bus),
    .temp        (temp),
    .duty        (duty),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  sp;
    logic [9:0]  code;
    logic [21:0] hi;
    int          stale;
    bit          stall;
    logic [9:0]  et;
    logic [7:0]  ed;
  } vec_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         pops = 0;
  int         get_pops = -1;
  int         proto_err = 0;
  bit         rand_full = 1'b0;
  logic [7:0] cmd_log[$];
  int         cmd_cyc[$];
  logic [7:0] rsp_q[$];
  vec_t       tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < cmd_log.size()) return {24'd0, cmd_log[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] cyc_at(input int i);
    if (i < cmd_cyc.size()) return cmd_cyc[i];
    return 32'hFFFF_FFFF;
  endfunction

  // Proportional gain of 4 (shift by 2), clipped to a byte.
  function automatic logic [7:0] ref_duty(input int sp, input int code);
    int e;
    e = (code - sp) * 4;
    if (e <= 0) return 8'd0;
    if (e > 255) return 8'd255;
    return e[7:0];
  endfunction

  task automatic upd_rsp();
    bus.rsp_rempty = (rsp_q.size() == 0);
    bus.rsp_rdata  = (rsp_q.size() == 0) ? 8'h00 : rsp_q[0];
  endtask

  task automatic push_rsp(input logic [7:0] b);
    rsp_q.push_back(b);
    upd_rsp();
  endtask

  // One clock: strobes are sampled mid-cycle, FIFO effects applied just
  // after the edge that commits them.
  task automatic step();
    logic       dw;
    logic       dp;
    logic [7:0] wd;
    @(negedge clk);
    dw = bus.cmd_winc;
    dp = bus.rsp_rinc;
    wd = bus.cmd_wdata;
    if (dw === 1'b1 && bus.cmd_wfull === 1'b1) proto_err++;
    @(posedge clk);
    #1;
    if (dw === 1'b1) begin
      cmd_log.push_back(wd);
      cmd_cyc.push_back(cyc);
      if (wd == 8'h01 && get_pops < 0) get_pops = pops;
    end
    if (dp === 1'b1) begin
      if (rsp_q.size() == 0) proto_err++;
      else void'(rsp_q.pop_front());
      pops++;
    end
    cyc++;
    upd_rsp();
    if (rand_full) bus.cmd_wfull = ($urandom_range(3) == 0);
  endtask

  task automatic run_txn(input logic [9:0] sp, input logic [9:0] code, input logic [21:0] hi,
                         input int n_stale, input logic [9:0] et, input logic [7:0] ed,
                         input bit stall, input bit timing, input bit ign_tick,
                         input bit drop_en, input string tag);
    logic [31:0] w;
    int          stale;
    int          t0;
    int          n_exp;
    bit          pushed;
    bit          done;
    bit          stalled;
    w = {hi, code};
    setpoint = sp;
    for (int i = 0; i < n_stale; i++) rsp_q.push_back(8'($urandom));
    upd_rsp();
    stale = rsp_q.size();
    cmd_log.delete();
    cmd_cyc.delete();
    pops = 0;
    get_pops = -1;
    n_exp = drop_en ? 6 : 5;
    t0 = cyc;
    tick = 1'b1;
    step();
    tick = 1'b0;
    pushed = 1'b0;
    done = 1'b0;
    stalled = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (!pushed && cmd_log.size() >= 1) begin
        for (int b = 0; b < 4; b++) rsp_q.push_back(w[8*b +: 8]);
        upd_rsp();
        pushed = 1'b1;
        if (ign_tick) tick = 1'b1;
        if (drop_en) enable = 1'b0;
      end
      if (stall && !stalled && cmd_log.size() == 2) begin
        bus.cmd_wfull = 1'b1;
        repeat (10) step();
        chk({tag, "_stall_nowrite"}, cmd_log.size(), 2);
        chk({tag, "_stall_busy"}, {31'd0, busy}, 1);
        bus.cmd_wfull = 1'b0;
        stalled = 1'b1;
      end
      step();
      tick = 1'b0;
      done = (cmd_log.size() >= n_exp) && !busy;
    end
    chk({tag, "_done"}, {31'd0, done}, 1);
    chk({tag, "_len"}, cmd_log.size(), n_exp);
    chk({tag, "_w0"}, log_at(0), 32'h01);
    chk({tag, "_w1"}, log_at(1), 32'h07);
    chk({tag, "_w2"}, log_at(2), {24'd0, ed});
    chk({tag, "_w3"}, log_at(3), 32'h08);
    chk({tag, "_w4"}, log_at(4), {24'd0, ed});
    if (drop_en) chk({tag, "_off"}, log_at(5), 32'h06);
    chk({tag, "_temp"}, {22'd0, temp}, {22'd0, et});
    chk({tag, "_duty"}, {24'd0, duty}, {24'd0, ed});
    chk({tag, "_toerr"}, {31'd0, timeout_err}, 0);
    chk({tag, "_drained"}, rsp_q.size(), 0);
    chk({tag, "_stale_first"}, get_pops, stale);
    if (timing) begin
      chk({tag, "_get_cyc"}, cyc_at(0), t0 + 2 + stale);
      chk({tag, "_p1_cyc"}, cyc_at(1), cyc_at(0) + 6);
      chk({tag, "_v1_cyc"}, cyc_at(2), cyc_at(1) + (stall ? 11 : 1));
      chk({tag, "_v2_cyc"}, cyc_at(4), cyc_at(2) + 2);
      if (drop_en) chk({tag, "_off_cyc"}, cyc_at(5), cyc_at(4) + 2);
    end
    if (ign_tick) begin
      repeat (4) step();
      chk({tag, "_no_queued_tick"}, cmd_log.size(), n_exp);
      chk({tag, "_idle"}, {31'd0, busy}, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         g;
    int         lim;
    logic [9:0] pt;
    logic [7:0] pd;
    logic [9:0] rsp_sp;
    int         c;

    tbl[0] = '{10'd500,  10'd500,  22'h000000, 0, 1'b0, 10'd500,  8'd0};
    tbl[1] = '{10'd500,  10'd540,  22'h2A5A5A, 0, 1'b0, 10'd540,  8'd160};
    tbl[2] = '{10'd500,  10'd600,  22'h3FFFFF, 0, 1'b0, 10'd600,  8'd255};
    tbl[3] = '{10'd500,  10'd600,  22'h15A5A5, 2, 1'b0, 10'd600,  8'd255};
    tbl[4] = '{10'd500,  10'd541,  22'h000001, 0, 1'b1, 10'd541,  8'd164};
    tbl[5] = '{10'd500,  10'd563,  22'h3C3C3C, 1, 1'b0, 10'd563,  8'd252};
    tbl[6] = '{10'd500,  10'd564,  22'h000000, 0, 1'b0, 10'd564,  8'd255};
    tbl[7] = '{10'd0,    10'd1023, 22'h3FFFFF, 3, 1'b0, 10'd1023, 8'd255};
    tbl[8] = '{10'd1023, 10'd0,    22'h3FFFFF, 0, 1'b0, 10'd0,    8'd0};
    tbl[9] = '{10'd100,  10'd101,  22'h123456, 0, 1'b0, 10'd101,  8'd4};

    rst = 1'b1;
    enable = 1'b0;
    tick = 1'b0;
    setpoint = 10'd0;
    bus.cmd_wfull = 1'b0;
    upd_rsp();
    repeat (3) step();
    chk("rst_winc", {31'd0, bus.cmd_winc}, 0);
    chk("rst_rinc", {31'd0, bus.rsp_rinc}, 0);
    chk("rst_wdata", {24'd0, bus.cmd_wdata}, 0);
    chk("rst_temp", {22'd0, temp}, 0);
    chk("rst_duty", {24'd0, duty}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_toerr", {31'd0, timeout_err}, 0);
    rst = 1'b0;
    step();

    // Enable with no tick: a single Peltier-on command.
    cmd_log.delete();
    cmd_cyc.delete();
    enable = 1'b1;
    repeat (6) step();
    chk("en_len", cmd_log.size(), 1);
    chk("en_w0", log_at(0), 32'h05);
    chk("en_idle", {31'd0, busy}, 0);

    for (int i = 0; i < 10; i++)
      run_txn(tbl[i].sp, tbl[i].code, tbl[i].hi, tbl[i].stale, tbl[i].et, tbl[i].ed,
              tbl[i].stall, 1'b1, 1'b0, 1'b0, $sformatf("tbl%0d", i));

    run_txn(10'd300, 10'd310, 22'h155555, 0, 10'd310, 8'd40, 1'b0, 1'b1, 1'b1, 1'b0, "igntick");

    // Enable dropped mid-cycle: cycle completes, then Peltier off; re-enable
    // brings the on command back.
    run_txn(10'd200, 10'd250, 22'h000000, 1, 10'd250, 8'd200, 1'b0, 1'b1, 1'b0, 1'b1, "dropen");
    enable = 1'b1;
    repeat (4) step();
    chk("reen_len", cmd_log.size(), 7);
    chk("reen_on", log_at(6), 32'h05);
    chk("reen_idle", {31'd0, busy}, 0);

    // Reset in the middle of COLLECT, rest of the response arrives late.
    cmd_log.delete();
    cmd_cyc.delete();
    setpoint = 10'd500;
    tick = 1'b1;
    step();
    tick = 1'b0;
    lim = 0;
    while (cmd_log.size() == 0 && lim < 20) begin
      step();
      lim++;
    end
    chk("rstmid_get", log_at(0), 32'h01);
    push_rsp(8'hAA);
    push_rsp(8'h03);
    repeat (3) step();
    chk("rstmid_busy_pre", {31'd0, busy}, 1);
    rst = 1'b1;
    step();
    chk("rstmid_busy", {31'd0, busy}, 0);
    chk("rstmid_temp", {22'd0, temp}, 0);
    chk("rstmid_duty", {24'd0, duty}, 0);
    chk("rstmid_winc", {31'd0, bus.cmd_winc}, 0);
    chk("rstmid_rinc", {31'd0, bus.rsp_rinc}, 0);
    chk("rstmid_wdata", {24'd0, bus.cmd_wdata}, 0);
    rst = 1'b0;
    push_rsp(8'h55);
    push_rsp(8'h66);
    repeat (4) step();
    chk("rstmid_on", log_at(cmd_log.size() - 1), 32'h05);
    chk("rstmid_idle", {31'd0, busy}, 0);
    run_txn(10'd400, 10'd450, 22'h0F0F0F, 0, 10'd450, 8'd200, 1'b0, 1'b1, 1'b0, 1'b0, "after_rst");

    // Response timeout: two bytes only, a third appears on the timeout cycle.
    pt = temp;
    pd = duty;
    cmd_log.delete();
    cmd_cyc.delete();
    setpoint = 10'd500;
    tick = 1'b1;
    step();
    tick = 1'b0;
    lim = 0;
    while (cmd_log.size() == 0 && lim < 20) begin
      step();
      lim++;
    end
    chk("to_get", log_at(0), 32'h01);
    g = cyc_at(0);
    push_rsp(8'hF4);
    push_rsp(8'h01);
    lim = 0;
    while (cyc < g + 20 && lim < 40) begin
      step();
      lim++;
    end
    chk("to_early_err", {31'd0, timeout_err}, 0);
    chk("to_early_busy", {31'd0, busy}, 1);
    push_rsp(8'h77);
    step();
    chk("to_err", {31'd0, timeout_err}, 1);
    chk("to_temp_kept", {22'd0, temp}, {22'd0, pt});
    chk("to_duty_kept", {24'd0, duty}, {24'd0, pd});
    chk("to_late_byte_kept", rsp_q.size(), 1);
`ifdef PELTIER_LOOP_FAILSAFE_EN
    chk("to_fs_busy", {31'd0, busy}, 1);
    lim = 0;
    while (!(cmd_log.size() >= 3 && !busy) && lim < 20) begin
      step();
      lim++;
    end
    chk("to_fs_len", cmd_log.size(), 3);
    chk("to_fs_off", log_at(1), 32'h06);
    chk("to_fs_off_cyc", cyc_at(1), g + 21);
    chk("to_fs_on", log_at(2), 32'h05);
`else
    chk("to_idle", {31'd0, busy}, 0);
    repeat (3) step();
    chk("to_no_write", cmd_log.size(), 1);
`endif
    run_txn(10'd500, 10'd540, 22'h000000, 0, 10'd540, 8'd160, 1'b0, 1'b1, 1'b0, 1'b0, "post_to");

    // Randomized cycles, half of them with a randomly full command FIFO.
    for (int r = 0; r < 40; r++) begin
      rsp_sp = 10'($urandom_range(1023));
      c = $urandom_range(1023);
      if (r % 3 == 0) begin
        c = int'(rsp_sp) + $urandom_range(75) - 5;
        if (c < 0) c = 0;
        if (c > 1023) c = 1023;
      end
      rand_full = (r % 2 == 1);
      if (!rand_full) bus.cmd_wfull = 1'b0;
      run_txn(rsp_sp, 10'(c), 22'($urandom), $urandom_range(3), 10'(c),
              ref_duty(int'(rsp_sp), c), 1'b0, !rand_full, 1'b0, 1'b0, $sformatf("rnd%0d", r));
    end
    rand_full = 1'b0;
    bus.cmd_wfull = 1'b0;
    step();
    chk("protocol", proto_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
